sm4_cbc_chainer: RTL and testbench

//  Cipher-block-chaining front/back end wrapped around sm4_encryptor. Accepts 128-bit

---
 rtl/sm4_cbc_chainer_pkg.sv | 23 ++
 rtl/sm4_cbc_chainer.sv | 128 ++++++++++++
 tb/tb_sm4_cbc_chainer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_cbc_chainer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sm4_cbc_chainer_pkg                                               |
// | Brief  : Shared types and encodings for the SM4 CBC chaining wrapper.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package sm4_cbc_chainer_pkg;

    typedef logic [127:0] sm4_block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } cbc_state_e;

    // Encoding presented on the core's encode_or_decode input
    localparam logic e_sm4_encrypt = 1'b0;
    localparam logic e_sm4_decrypt = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sm4_cbc_chainer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sm4_cbc_chainer                                                   |
// | Brief  : CBC/ECB front and back end around an SM4 core, one block in flight|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sm4_cbc_chainer
    import sm4_cbc_chainer_pkg::*;
#(
    parameter bit enable_cbc_p = 1'b1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic         decrypt_i,
    input  logic         first_i,
    input  logic         v_i,
    output logic         ready_o,
    output logic [127:0] data_o,
    output logic         v_o,
    input  logic         yumi_i,
    output logic [127:0] core_content_o,
    output logic [127:0] core_key_o,
    output logic         core_encode_or_decode_o,
    output logic         core_v_o,
    input  logic         core_ready_i,
    input  logic [127:0] core_crypt_i,
    input  logic         core_v_i,
    output logic         core_yumi_o,
    output logic         core_invalid_cache_o
);

    cbc_state_e r_state;
    cbc_state_e w_state_nxt;
    sm4_block_t r_data;
    sm4_block_t r_chain;
    sm4_block_t r_key;
    sm4_block_t r_data_o;
    logic       r_mode;
    logic       r_key_valid;
    logic       r_invalid;
    sm4_block_t w_chain;
    logic       w_key_change;

    // ECB build forces every chain XOR operand to zero
    assign w_chain      = enable_cbc_p ? r_chain : '0;
    assign w_key_change = !r_key_valid || (key_i != r_key);

    always_comb begin
        w_state_nxt    = r_state;
        ready_o        = 1'b0;
        v_o            = 1'b0;
        core_v_o       = 1'b0;
        core_yumi_o    = 1'b0;
        core_content_o = r_mode ? r_data : (r_data ^ w_chain);
        case (r_state)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (v_i) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_v_o = 1'b1;
                if (core_ready_i) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                core_yumi_o = core_v_i;
                if (core_v_i) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                v_o = 1'b1;
                if (yumi_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_chain     <= '0;
            r_key       <= '0;
            r_data_o    <= '0;
            r_mode      <= 1'b0;
            r_key_valid <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_invalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (v_i) begin
                        r_data <= data_i;
                        if (first_i) begin
                            r_chain     <= iv_i;
                            r_mode      <= decrypt_i;
                            r_key       <= key_i;
                            r_key_valid <= 1'b1;
                            r_invalid   <= w_key_change;
                        end
                    end
                end
                ST_WAIT: begin
                    // Decrypt chains on the received ciphertext, encrypt on the produced one
                    if (core_v_i) begin
                        if (r_mode) begin
                            r_data_o <= core_crypt_i ^ w_chain;
                            r_chain  <= r_data;
                        end else begin
                            r_data_o <= core_crypt_i;
                            r_chain  <= core_crypt_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o                  = r_data_o;
    assign core_key_o              = r_key;
    assign core_invalid_cache_o    = r_invalid;
    assign core_encode_or_decode_o = r_mode ? e_sm4_decrypt : e_sm4_encrypt;

endmodule
`default_nettype wire

// File: tb/tb_sm4_cbc_chainer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sm4_cbc_chainer                                                |
// | Brief  : Scoreboard bench: CBC instance (0) and ECB instance (1).          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sm4_cbc_chainer;
    import sm4_cbc_chainer_pkg::*;

    localparam sm4_block_t K_GB = 128'h0123456789abcdeffedcba9876543210;
    localparam sm4_block_t P_GB = 128'h0123456789abcdeffedcba9876543210;
    localparam sm4_block_t C_GB = 128'h681edf34d206965e86b3e94f536e4246;
    localparam sm4_block_t K_2  = 128'h00112233445566778899aabbccddeeff;
    localparam sm4_block_t MASK = 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
    localparam int         CORE_LAT = 2;

    logic       clk, rst;
    sm4_block_t data_i, key_i, iv_i;
    logic       decrypt_i, first_i;
    logic [1:0] v_i, ready_o, v_o, yumi_i;
    logic [1:0] core_eod, core_v_o, core_ready_i, core_v_i, core_yumi_o, core_inv;
    logic [1:0] cbusy, stall;
    sm4_block_t data_o [2];
    sm4_block_t core_content_o [2];
    sm4_block_t core_key_o [2];
    sm4_block_t core_crypt_i [2];
    sm4_block_t cres [2];
    int         ccnt [2];
    int         inv_cnt [2];
    logic [1:0] seen;
    sm4_block_t q0 [$];
    sm4_block_t q1 [$];
    sm4_block_t mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;

    sm4_cbc_chainer #(.enable_cbc_p(1'b1)) dut (
        .clk_i(clk), .reset_i(rst), .data_i(data_i), .key_i(key_i), .iv_i(iv_i),
        .decrypt_i(decrypt_i), .first_i(first_i), .v_i(v_i[0]), .ready_o(ready_o[0]),
        .data_o(data_o[0]), .v_o(v_o[0]), .yumi_i(yumi_i[0]),
        .core_content_o(core_content_o[0]), .core_key_o(core_key_o[0]),
        .core_encode_or_decode_o(core_eod[0]), .core_v_o(core_v_o[0]),
        .core_ready_i(core_ready_i[0]), .core_crypt_i(core_crypt_i[0]),
        .core_v_i(core_v_i[0]), .core_yumi_o(core_yumi_o[0]),
        .core_invalid_cache_o(core_inv[0]));

    sm4_cbc_chainer #(.enable_cbc_p(1'b0)) dut_ecb (
        .clk_i(clk), .reset_i(rst), .data_i(data_i), .key_i(key_i), .iv_i(iv_i),
        .decrypt_i(decrypt_i), .first_i(first_i), .v_i(v_i[1]), .ready_o(ready_o[1]),
        .data_o(data_o[1]), .v_o(v_o[1]), .yumi_i(yumi_i[1]),
        .core_content_o(core_content_o[1]), .core_key_o(core_key_o[1]),
        .core_encode_or_decode_o(core_eod[1]), .core_v_o(core_v_o[1]),
        .core_ready_i(core_ready_i[1]), .core_crypt_i(core_crypt_i[1]),
        .core_v_i(core_v_i[1]), .core_yumi_o(core_yumi_o[1]),
        .core_invalid_cache_o(core_inv[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in block cipher: invertible toy transform with the GB/T 32907 pair pinned
    function automatic sm4_block_t toy_enc(input sm4_block_t x, input sm4_block_t k);
        if (k == K_GB && x == P_GB) return C_GB;
        return {x[120:0], x[127:121]} ^ k ^ MASK;
    endfunction

    function automatic sm4_block_t toy_dec(input sm4_block_t y, input sm4_block_t k);
        sm4_block_t t;
        if (k == K_GB && y == C_GB) return P_GB;
        t = y ^ k ^ MASK;
        return {t[6:0], t[127:7]};
    endfunction

    assign core_ready_i = ~cbusy & ~core_v_i & ~stall;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                cbusy[u]    <= 1'b0;
                core_v_i[u] <= 1'b0;
                ccnt[u]     <= 0;
            end else begin
                if (core_v_i[u] && core_yumi_o[u]) core_v_i[u] <= 1'b0;
                if (core_v_o[u] && core_ready_i[u]) begin
                    cbusy[u] <= 1'b1;
                    ccnt[u]  <= CORE_LAT;
                    cres[u]  <= (core_eod[u] == e_sm4_decrypt)
                                ? toy_dec(core_content_o[u], core_key_o[u])
                                : toy_enc(core_content_o[u], core_key_o[u]);
                end else if (cbusy[u]) begin
                    if (ccnt[u] == 0) begin
                        core_v_i[u]     <= 1'b1;
                        core_crypt_i[u] <= cres[u];
                        cbusy[u]        <= 1'b0;
                    end else begin
                        ccnt[u] <= ccnt[u] - 1;
                    end
                end
            end
        end
    end

    initial begin
        inv_cnt[0] = 0;
        inv_cnt[1] = 0;
    end
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++)
            if (core_inv[u]) inv_cnt[u] <= inv_cnt[u] + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented result against the scoreboard head
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                seen[u] = 1'b0;
            end else if (v_o[u] && !seen[u]) begin
                seen[u] = 1'b1;
                if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("unexpected_out%0d", u), data_o[u], '0);
                    if (data_o[u] == '0) begin
                        n_fail++;
                        $display("FAIL unexpected_out%0d actual=%h required=none", u, data_o[u]);
                    end
                end else begin
                    mon_e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("data_o%0d", u), data_o[u], mon_e);
                end
            end else if (!v_o[u]) begin
                seen[u] = 1'b0;
            end
        end
    end

    task automatic send(input int u, input sm4_block_t d, input bit first, input sm4_block_t k,
                        input sm4_block_t iv, input bit dec, input bit push, input sm4_block_t exp);
        int t = 0;
        while (!ready_o[u] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!ready_o[u]) check("send_ready_timeout", {127'd0, ready_o[u]}, 128'd1);
        data_i = d; first_i = first; key_i = k; iv_i = iv; decrypt_i = dec;
        if (push) begin
            if (u == 0) q0.push_back(exp);
            else        q1.push_back(exp);
        end
        v_i[u] = 1'b1;
        @(posedge clk); #1;
        v_i[u] = 1'b0;
        first_i = 1'b0;
    endtask

    task automatic take(input int u, input int hold);
        int t = 0;
        while (!v_o[u] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!v_o[u]) check("take_vo_timeout", {127'd0, v_o[u]}, 128'd1);
        repeat (hold) begin @(posedge clk); #1; end
        yumi_i[u] = 1'b1;
        @(posedge clk); #1;
        yumi_i[u] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sm4_block_t e1, e2, hold_d, hold_c;
        int  inv0;
        logic ok;
        rst = 1'b1; v_i = '0; yumi_i = '0; stall = '0;
        data_i = '0; key_i = '0; iv_i = '0; decrypt_i = 1'b0; first_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {126'd0, ready_o}, 128'd3);
        check("rst_v_o", {126'd0, v_o}, 128'd0);
        check("rst_core_v", {126'd0, core_v_o}, 128'd0);
        check("rst_core_yumi", {126'd0, core_yumi_o}, 128'd0);
        check("rst_invalid", {126'd0, core_inv}, 128'd0);
        check("rst_data_o", data_o[0], '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer encrypt, first key load pulses invalidate once
        inv0 = inv_cnt[0];
        send(0, P_GB, 1'b1, K_GB, '0, 1'b0, 1'b1, C_GB);
        take(0, 0);
        check("kat_invalid_pulses", inv_cnt[0] - inv0, 128'd1);

        // Two-block CBC encrypt then decrypt with the same IV; same key -> no pulse
        e1 = toy_enc(P_GB ^ C_GB, K_GB);
        e2 = toy_enc(P_GB ^ e1, K_GB);
        inv0 = inv_cnt[0];
        send(0, P_GB, 1'b1, K_GB, C_GB, 1'b0, 1'b1, e1); take(0, 0);
        send(0, P_GB, 1'b0, '0, '0, 1'b0, 1'b1, e2);      take(0, 0);
        send(0, e1, 1'b1, K_GB, C_GB, 1'b1, 1'b1, P_GB);  take(0, 0);
        send(0, e2, 1'b0, '0, '0, 1'b0, 1'b1, P_GB);      take(0, 0);
        check("same_key_no_pulse", inv_cnt[0] - inv0, 128'd0);

        // Key change pulses once; reusing it afterwards does not
        inv0 = inv_cnt[0];
        send(0, P_GB, 1'b1, K_2, '0, 1'b0, 1'b1, toy_enc(P_GB, K_2)); take(0, 0);
        check("key_change_pulse", inv_cnt[0] - inv0, 128'd1);
        inv0 = inv_cnt[0];
        send(0, C_GB, 1'b1, K_2, '0, 1'b0, 1'b1, toy_enc(C_GB, K_2)); take(0, 0);
        check("key_reuse_no_pulse", inv_cnt[0] - inv0, 128'd0);

        // Host back-pressure in OUT
        send(0, P_GB, 1'b1, K_GB, '0, 1'b0, 1'b1, C_GB);
        while (!v_o[0]) begin @(posedge clk); #1; end
        hold_d = data_o[0];
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (data_o[0] !== hold_d || v_o[0] !== 1'b1 || ready_o[0] !== 1'b0) ok = 1'b0;
        end
        check("out_hold_stable", {127'd0, ok}, 128'd1);
        yumi_i[0] = 1'b1;
        @(posedge clk); #1;
        yumi_i[0] = 1'b0;
        check("ready_after_yumi", {127'd0, ready_o[0]}, 128'd1);
        check("vo_after_yumi", {127'd0, v_o[0]}, 128'd0);

        // Core back-pressure in ISSUE
        stall[0] = 1'b1;
        send(0, P_GB, 1'b1, K_GB, C_GB, 1'b0, 1'b1, toy_enc(P_GB ^ C_GB, K_GB));
        hold_c = core_content_o[0];
        check("issue_content", hold_c, P_GB ^ C_GB);
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (core_v_o[0] !== 1'b1 || core_content_o[0] !== hold_c) ok = 1'b0;
        end
        check("issue_hold_stable", {127'd0, ok}, 128'd1);
        stall[0] = 1'b0;
        take(0, 0);

        // Reset while waiting on the core drops the block
        send(0, P_GB, 1'b1, K_GB, '0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("wait_rst_ready", {127'd0, ready_o[0]}, 128'd1);
        check("wait_rst_v_o", {127'd0, v_o[0]}, 128'd0);
        check("wait_rst_core_v", {127'd0, core_v_o[0]}, 128'd0);

        // After reset: chain and key are zero; key_valid clear forces a pulse even for key 0
        send(0, P_GB, 1'b0, K_GB, C_GB, 1'b0, 1'b1, toy_enc(P_GB, '0)); take(0, 0);
        inv0 = inv_cnt[0];
        send(0, C_GB, 1'b1, '0, '0, 1'b0, 1'b1, toy_enc(C_GB, '0)); take(0, 0);
        check("post_rst_key0_pulse", inv_cnt[0] - inv0, 128'd1);

        // ECB instance: nonzero IV must have no effect
        send(1, P_GB, 1'b1, K_GB, C_GB, 1'b0, 1'b1, C_GB); take(1, 0);
        send(1, P_GB, 1'b0, '0, '0, 1'b0, 1'b1, C_GB);     take(1, 0);
        send(1, C_GB, 1'b1, K_GB, C_GB, 1'b1, 1'b1, P_GB); take(1, 0);

        repeat (5) @(posedge clk);
        #1;
        check("sb0_drained", q0.size(), 128'd0);
        check("sb1_drained", q1.size(), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
